and_nbm_persist: RTL and testbench
==================================

// Module: and_nbm_persist
// PURPOSE
//   Registered N-input AND gate with per-input inversion mask and a persistence filter.
//   Generalises the fixed 4-input/1-inverted combinational AND primitive to WIDTH inputs
//   with an arbitrary inversion mask, clocked sampling and optional sticky output.
//   O asserts only after HOLD consecutive qualified matches.
//   Used as a qualified pattern/condition detector in clocked primitive-level designs.
// PARAMETERS
//   WIDTH     4         number of inputs, 1..64
//   INV_MASK  4'b0001   bit i = 1 inverts I[i] before the AND; only bits [WIDTH-1:0] are used
//   HOLD      1         consecutive qualified matches required before O asserts, 1..65535
//   STICKY    0         0 = O follows the filtered match; 1 = O latches until ACK or reset
// PORTS
//   C      in   1           clock, rising edge
//   CLRN   in   1           asynchronous active-low reset
//   CE     in   1           sample enable; qualifies I
//   I      in   WIDTH       data inputs
//   ACK    in   1           synchronous clear of O and CNT
//   O      out  1           filtered / latched match, registered
//   MATCH  out  1           raw match of the last qualified sample, registered
//   CNT    out  CW          run length, CW = $clog2(HOLD+1)
// BEHAVIOUR
//   - Combinational match m = &(I ^ INV_MASK[WIDTH-1:0]).
//   - Reset: CLRN low clears O, MATCH and CNT to 0 asynchronously, independent of C.
//     Deassertion takes effect at the next rising edge of C.
//   - Priority at each rising edge of C, highest first:
//     1. ACK=1: CNT<=0 and O<=0, regardless of CE, I or STICKY.
//        MATCH still updates if CE=1.
//     2. CE=0: all registers hold.
//     3. CE=1:
//        - MATCH<=m.
//        - m=1: CNT<=min(CNT+1, HOLD); CNT saturates at HOLD and never wraps.
//        - m=0: CNT<=0.
//   - O when ACK=0 and CE=1:
//     - STICKY=0: O<=(m && CNT+1>=HOLD); O drops on the first mismatching qualified sample.
//     - STICKY=1: O<=O | (m && CNT+1>=HOLD); O stays 1 through mismatches.
//   - ACK coincident with a completing match: ACK wins, so O=0 and CNT=0.
//     The run restarts on the next qualified match.
//   - Latency: O rises on the same edge that captures the HOLD-th consecutive matching
//     qualified sample.
//   - HOLD=1, STICKY=0: O == MATCH, i.e. a registered AND-with-inverted-inputs.
//   - CE gaps do not break a run: only qualified samples count.
//   - Elaboration error if WIDTH<1, WIDTH>64, HOLD<1 or HOLD>65535.
// TESTING
//   1. WIDTH=4, INV_MASK=0001, HOLD=1, CE=1; sweep I over all 16 values.
//      -> O=MATCH=1 only the edge after I=4'b1110, 0 otherwise.
//   2. HOLD=3: I=1110 for 3 edges -> O=1 on 3rd edge, CNT=3.
//      Repeat with I=1111 on 2nd edge -> CNT=0, O stays 0.
//   3. HOLD=3: match, CE=0 for 5 cycles with I=0000, then match, match
//      -> CNT 1,1,2,3; O=1 on the final edge.
//   4. STICKY=1, HOLD=2: 2 matches -> O=1; I=0000 -> O stays 1; ACK=1 -> O=0, CNT=0 next edge.
//      ACK together with a completing match -> O=0.
//   5. HOLD=4: CLRN pulsed low between edges at CNT=2 -> O, MATCH, CNT=0 immediately.
//      After release, 4 matches needed for O=1.
//   6. WIDTH=32, INV_MASK=32'hFFFF0000, HOLD=1: I=32'h0000FFFF -> O=1;
//      I=32'h0000FFFE -> O=0; HOLD=65535 saturation check on CNT.

Source files
------------

// File: rtl/and_nbm_persist_if.sv
// Signal bundle for and_nbm_persist.
//   CE    sample enable (qualifies I)
//   I     WIDTH data inputs
//   ACK   synchronous clear of O and CNT
//   O     filtered / latched match (registered)
//   MATCH raw match of the last qualified sample (registered)
//   CNT   run length of consecutive qualified matches, CW bits
// master: the side that drives CE/I/ACK. slave: the detector itself.
// CW must equal $clog2(HOLD+1) of the attached detector.
interface and_nbm_persist_if #(
  parameter int WIDTH = 4,
  parameter int CW    = 1
);
  logic             CE;
  logic [WIDTH-1:0] I;
  logic             ACK;
  logic             O;
  logic             MATCH;
  logic [CW-1:0]    CNT;

  modport master (output CE, output I, output ACK,
                  input  O, input MATCH, input CNT);
  modport slave  (input  CE, input I, input ACK,
                  output O, output MATCH, output CNT);
endinterface

// File: rtl/and_nbm_persist.sv
// Registered WIDTH-input AND with per-input inversion mask and a persistence
// filter. O asserts once HOLD consecutive qualified (CE=1) samples have
// matched; with STICKY=1 it then stays set until ACK or reset.
// Ports:
//   C     clock, rising edge
//   CLRN  asynchronous active-low reset of O, MATCH and CNT
//   bus   and_nbm_persist_if slave modport (CE, I, ACK in; O, MATCH, CNT out)
module and_nbm_persist #(
  parameter int          WIDTH    = 4,
  parameter logic [63:0] INV_MASK = 64'h1,
  parameter int          HOLD     = 1,
  parameter bit          STICKY   = 1'b0
) (
  input  logic                  C,
  input  logic                  CLRN,
  and_nbm_persist_if.slave      bus
);
  localparam int CW = $clog2(HOLD + 1);
  // One extra bit so CNT+1 never overflows before comparison with HOLD.
  localparam logic [CW:0] HOLD_X = (CW + 1)'(HOLD);

  generate
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("and_nbm_persist: WIDTH must be 1..64");
    end
    if (HOLD < 1 || HOLD > 65535) begin : g_bad_hold
      $error("and_nbm_persist: HOLD must be 1..65535");
    end
  endgenerate

  logic          o_reg, o_next;
  logic          match_reg, match_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic          m;
  logic [CW:0]   cnt_inc;
  logic          complete;

  assign m        = &(bus.I ^ INV_MASK[WIDTH-1:0]);
  assign cnt_inc  = {1'b0, cnt_reg} + 1'b1;
  // This sample finishes (or extends) a run of at least HOLD matches.
  assign complete = m && (cnt_inc >= HOLD_X);

  always_comb begin
    o_next     = o_reg;
    match_next = match_reg;
    cnt_next   = cnt_reg;
    if (bus.CE) begin
      match_next = m;
      if (!m)
        cnt_next = '0;
      else if (complete)
        cnt_next = HOLD_X[CW-1:0];  // saturate, never wrap
      else
        cnt_next = cnt_inc[CW-1:0];
      o_next = STICKY ? (o_reg | complete) : complete;
    end
    // ACK overrides the run state but leaves MATCH tracking the sample.
    if (bus.ACK) begin
      cnt_next = '0;
      o_next   = 1'b0;
    end
  end

  always_ff @(posedge C or negedge CLRN) begin
    if (!CLRN) begin
      o_reg     <= 1'b0;
      match_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      o_reg     <= o_next;
      match_reg <= match_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.O     = o_reg;
  assign bus.MATCH = match_reg;
  assign bus.CNT   = cnt_reg;
endmodule

// File: tb/tb_and_nbm_persist.sv
// Directed bench: several detector configurations share one clock; each is
// exercised in turn while the others sit with CE=0.
module tb_and_nbm_persist;
  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  localparam int CW1 = $clog2(1 + 1);
  localparam int CW3 = $clog2(3 + 1);
  localparam int CW2 = $clog2(2 + 1);
  localparam int CW4 = $clog2(4 + 1);
  localparam int CWS = $clog2(65535 + 1);

  and_nbm_persist_if #(.WIDTH(4),  .CW(CW1)) if1  ();
  and_nbm_persist_if #(.WIDTH(4),  .CW(CW3)) if3  ();
  and_nbm_persist_if #(.WIDTH(4),  .CW(CW2)) if2s ();
  and_nbm_persist_if #(.WIDTH(4),  .CW(CW4)) if4  ();
  and_nbm_persist_if #(.WIDTH(32), .CW(CW1)) if32 ();
  and_nbm_persist_if #(.WIDTH(4),  .CW(CWS)) ifs  ();

  and_nbm_persist #(.WIDTH(4), .INV_MASK(64'h1), .HOLD(1), .STICKY(1'b0))
    u1 (.C(clk), .CLRN(rst_n), .bus(if1));
  and_nbm_persist #(.WIDTH(4), .INV_MASK(64'h1), .HOLD(3), .STICKY(1'b0))
    u3 (.C(clk), .CLRN(rst_n), .bus(if3));
  and_nbm_persist #(.WIDTH(4), .INV_MASK(64'h1), .HOLD(2), .STICKY(1'b1))
    u2s (.C(clk), .CLRN(rst_n), .bus(if2s));
  and_nbm_persist #(.WIDTH(4), .INV_MASK(64'h1), .HOLD(4), .STICKY(1'b0))
    u4 (.C(clk), .CLRN(rst4_n), .bus(if4));
  and_nbm_persist #(.WIDTH(32), .INV_MASK(64'hFFFF0000), .HOLD(1), .STICKY(1'b0))
    u32 (.C(clk), .CLRN(rst_n), .bus(if32));
  and_nbm_persist #(.WIDTH(4), .INV_MASK(64'h1), .HOLD(65535), .STICKY(1'b0))
    us (.C(clk), .CLRN(rst_n), .bus(ifs));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    if1.CE  = 0; if1.I  = '0; if1.ACK  = 0;
    if3.CE  = 0; if3.I  = '0; if3.ACK  = 0;
    if2s.CE = 0; if2s.I = '0; if2s.ACK = 0;
    if4.CE  = 0; if4.I  = '0; if4.ACK  = 0;
    if32.CE = 0; if32.I = '0; if32.ACK = 0;
    ifs.CE  = 0; ifs.I  = '0; ifs.ACK  = 0;
    step(); step();
    check("rst_o",     64'(if1.O),     64'd0);
    check("rst_match", 64'(if1.MATCH), 64'd0);
    check("rst_cnt3",  64'(if3.CNT),   64'd0);
    check("rst_cnts",  64'(ifs.CNT),   64'd0);
    rst_n  = 1'b1;
    rst4_n = 1'b1;

    // 1: HOLD=1 sweep, only I=1110 matches; O mirrors MATCH.
    if1.CE = 1;
    for (int v = 0; v < 16; v++) begin
      if1.I = 4'(v);
      step();
      check($sformatf("sweep_o_%0d", v),     64'(if1.O),     64'(v == 14));
      check($sformatf("sweep_match_%0d", v), 64'(if1.MATCH), 64'(v == 14));
      $display("sweep I=%0h O=%0b MATCH=%0b", v, if1.O, if1.MATCH);
    end
    if1.CE = 0;

    // 2: HOLD=3 run of three, saturation, then broken run.
    if3.CE = 1; if3.I = 4'b1110;
    step(); check("h3_cnt1", 64'(if3.CNT), 64'd1); check("h3_o1", 64'(if3.O), 64'd0);
    step(); check("h3_cnt2", 64'(if3.CNT), 64'd2); check("h3_o2", 64'(if3.O), 64'd0);
    step(); check("h3_cnt3", 64'(if3.CNT), 64'd3); check("h3_o3", 64'(if3.O), 64'd1);
    step(); check("h3_sat",  64'(if3.CNT), 64'd3); check("h3_o4", 64'(if3.O), 64'd1);
    if3.I = 4'b1111;
    step(); check("h3_brk_cnt", 64'(if3.CNT), 64'd0); check("h3_brk_o", 64'(if3.O), 64'd0);
    check("h3_brk_match", 64'(if3.MATCH), 64'd0);
    if3.I = 4'b1110;
    step(); check("h3_r_cnt1", 64'(if3.CNT), 64'd1);
    if3.I = 4'b1111;
    step(); check("h3_r_cnt0", 64'(if3.CNT), 64'd0); check("h3_r_o", 64'(if3.O), 64'd0);
    $display("hold3 run/break CNT=%0d O=%0b", if3.CNT, if3.O);

    // 3: CE gaps do not break a run.
    if3.I = 4'b1110;
    step(); check("gap_cnt1", 64'(if3.CNT), 64'd1);
    if3.CE = 0; if3.I = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step(); check($sformatf("gap_hold_%0d", k), 64'(if3.CNT), 64'd1);
    end
    check("gap_match_held", 64'(if3.MATCH), 64'd1);
    if3.CE = 1; if3.I = 4'b1110;
    step(); check("gap_cnt2", 64'(if3.CNT), 64'd2); check("gap_o2", 64'(if3.O), 64'd0);
    step(); check("gap_cnt3", 64'(if3.CNT), 64'd3); check("gap_o3", 64'(if3.O), 64'd1);
    if3.CE = 0;
    $display("ce-gap run CNT=%0d O=%0b", if3.CNT, if3.O);

    // 4: STICKY, HOLD=2, ACK behaviour.
    if2s.CE = 1; if2s.I = 4'b1110;
    step(); check("st_cnt1", 64'(if2s.CNT), 64'd1); check("st_o1", 64'(if2s.O), 64'd0);
    step(); check("st_cnt2", 64'(if2s.CNT), 64'd2); check("st_o2", 64'(if2s.O), 64'd1);
    if2s.I = 4'b0000;
    step(); check("st_keep_o", 64'(if2s.O), 64'd1); check("st_keep_cnt", 64'(if2s.CNT), 64'd0);
    check("st_keep_match", 64'(if2s.MATCH), 64'd0);
    if2s.ACK = 1;
    step(); check("st_ack_o", 64'(if2s.O), 64'd0); check("st_ack_cnt", 64'(if2s.CNT), 64'd0);
    if2s.ACK = 0; if2s.I = 4'b1110;
    step(); check("st_r_cnt1", 64'(if2s.CNT), 64'd1);
    if2s.ACK = 1;
    step(); check("st_ackwin_o", 64'(if2s.O), 64'd0); check("st_ackwin_cnt", 64'(if2s.CNT), 64'd0);
    check("st_ackwin_match", 64'(if2s.MATCH), 64'd1);
    if2s.ACK = 0;
    step(); check("st_rs_cnt1", 64'(if2s.CNT), 64'd1); check("st_rs_o1", 64'(if2s.O), 64'd0);
    step(); check("st_rs_o2", 64'(if2s.O), 64'd1);
    if2s.CE = 0;
    $display("sticky ack sequence O=%0b CNT=%0d", if2s.O, if2s.CNT);

    // 5: asynchronous reset mid-cycle at CNT=2.
    if4.CE = 1; if4.I = 4'b1110;
    step(); step();
    check("ar_pre_cnt", 64'(if4.CNT), 64'd2);
    #2 rst4_n = 1'b0;
    #1;
    check("ar_cnt",   64'(if4.CNT),   64'd0);
    check("ar_match", 64'(if4.MATCH), 64'd0);
    check("ar_o",     64'(if4.O),     64'd0);
    rst4_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("ar_run_cnt%0d", k), 64'(if4.CNT), 64'(k));
      check($sformatf("ar_run_o%0d", k),   64'(if4.O),   64'(k == 4));
    end
    if4.CE = 0;
    $display("async reset then run CNT=%0d O=%0b", if4.CNT, if4.O);

    // 6: wide mask and HOLD=65535 saturation.
    if32.CE = 1; if32.I = 32'h0000FFFF;
    step(); check("w32_match_o", 64'(if32.O), 64'd1);
    if32.I = 32'h0000FFFE;
    step(); check("w32_miss_o", 64'(if32.O), 64'd0);
    if32.I = 32'hFFFFFFFF;
    step(); check("w32_inv_o", 64'(if32.O), 64'd0); check("w32_inv_m", 64'(if32.MATCH), 64'd0);
    if32.CE = 0;
    $display("width32 O=%0b", if32.O);

    ifs.CE = 1; ifs.I = 4'b1110;
    for (int k = 0; k < 65534; k++) step();
    check("sat_cnt_pre", 64'(ifs.CNT), 64'd65534); check("sat_o_pre", 64'(ifs.O), 64'd0);
    step(); check("sat_cnt", 64'(ifs.CNT), 64'd65535); check("sat_o", 64'(ifs.O), 64'd1);
    step(); check("sat_nowrap", 64'(ifs.CNT), 64'd65535); check("sat_o_hold", 64'(ifs.O), 64'd1);
    ifs.CE = 0;
    $display("hold65535 CNT=%0d O=%0b", ifs.CNT, ifs.O);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
